// File: rtl/column_write_dispatch_pkg.sv
// Shared definitions for the column write dispatcher.
//   DEPTH   : default column buffer depth (2^6 words)
//   clog2   : width helper that never returns 0, so 1-entry ranges still get a 1-bit field
//   state_e : dispatcher FSM encoding
package column_write_dispatch_pkg;

  localparam int unsigned DefAddrWidth = 6;
  localparam int unsigned DEPTH        = 2 ** DefAddrWidth;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return (res == 0) ? 1 : res;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/column_write_dispatch_if.sv
// Stream and column-buffer bus of the column write dispatcher.
//   in_valid/in_data/in_last/in_ready : upstream activation stream
//   rd_ack                            : per-column pop strobes from the read side
//   wr_req_p/wr_data_p                : per-column write strobes and data
// master: upstream/read-side driver; slave: the dispatcher.
interface column_write_dispatch_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_COL    = 4
) ();

  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_last;
  logic                          in_ready;
  logic [NUM_COL-1:0]            rd_ack;
  logic [NUM_COL-1:0]            wr_req_p;
  logic [NUM_COL*DATA_WIDTH-1:0] wr_data_p;

  modport master (
    output in_valid, in_data, in_last, rd_ack,
    input  in_ready, wr_req_p, wr_data_p
  );

  modport slave (
    input  in_valid, in_data, in_last, rd_ack,
    output in_ready, wr_req_p, wr_data_p
  );

endinterface

// File: rtl/column_write_dispatch_col_occ_counter.sv
// col_occ_counter: per-column occupancy tracker.
//   clk, reset    : clock, synchronous active-high reset
//   inc_i         : one word written to the column this cycle
//   dec_i         : one word popped from the column this cycle
//   cnt_o         : current occupancy (0..MaxCount)
//   underflow_o   : pop seen while empty (combinational pulse)
// Saturates at both ends; a simultaneous write and pop leaves the count unchanged.
module column_write_dispatch_col_occ_counter #(
  parameter int unsigned Width    = 7,
  parameter int unsigned MaxCount = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             underflow_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q != Width'(MaxCount)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        underflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/column_write_dispatch.sv
// Column write dispatcher: deals an upstream word stream into NUM_COL column buffers
// in ROW_LEN-word bursts, round-robin, with per-column occupancy flow control.
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : in_valid/in_data/in_last/in_ready stream, rd_ack pops,
//                 wr_req_p/wr_data_p registered column writes (1-cycle latency)
//   col_ptr     : column currently being filled
//   frame_done  : one-cycle pulse after the last word of a frame is written
//   ovf_err     : sticky, set when a column is popped while empty
module column_write_dispatch
  import column_write_dispatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned ROW_LEN    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  column_write_dispatch_if.slave     bus,
  output logic [clog2(NUM_COL)-1:0]  col_ptr,
  output logic                       frame_done,
  output logic                       ovf_err
);

  localparam int unsigned ColDepth = 1 << ADDR_WIDTH;
  localparam int unsigned OccW     = ADDR_WIDTH + 1;
  localparam int unsigned ColW     = clog2(NUM_COL);
  localparam int unsigned CntW     = clog2(ROW_LEN + 1);

  state_e                        state_q, state_d;
  logic [ColW-1:0]               col_q, col_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [NUM_COL-1:0]            wr_req_q, wr_req_d;
  logic [NUM_COL*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                          ovf_q, ovf_d;

  logic [NUM_COL-1:0][OccW-1:0]  occ;
  logic [NUM_COL-1:0]            occ_inc;
  logic [NUM_COL-1:0]            underflow;
  logic                          ready;
  logic                          accept;

  // Gated by reset so the port reads 0 while reset is held.
  assign ready  = !reset && (state_q != StDone) && (occ[col_q] != OccW'(ColDepth));
  assign accept = bus.in_valid && ready;

  always_comb begin
    occ_inc = '0;
    if (accept) begin
      occ_inc[col_q] = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_COL; c++) begin : g_occ
    column_write_dispatch_col_occ_counter #(
      .Width    (OccW),
      .MaxCount (ColDepth)
    ) u_occ (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (occ_inc[c]),
      .dec_i       (bus.rd_ack[c]),
      .cnt_o       (occ[c]),
      .underflow_o (underflow[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    wr_req_d  = '0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q | (|underflow);

    if (accept) begin
      wr_req_d[col_q] = 1'b1;
      wr_data_d[int'(col_q) * DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
      if (bus.in_last) begin
        // Frame end realigns to column 0 even on a partial row.
        state_d = StDone;
        col_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = StFill;
        if (cnt_q == CntW'(ROW_LEN - 1)) begin
          cnt_d = '0;
          col_d = (col_q == ColW'(NUM_COL - 1)) ? '0 : col_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      col_q     <= '0;
      cnt_q     <= '0;
      wr_req_q  <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.wr_req_p  = wr_req_q;
  assign bus.wr_data_p = wr_data_q;
  assign col_ptr       = col_q;
  assign frame_done    = (state_q == StDone);
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_column_write_dispatch.sv
module tb_column_write_dispatch;
  import column_write_dispatch_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int NC  = 4;
  localparam int RL  = 16;
  localparam int DEP = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] col_ptr;
  logic       frame_done;
  logic       ovf_err;

  always #5 clk = ~clk;

  column_write_dispatch_if #(.DATA_WIDTH(DW), .NUM_COL(NC)) bus ();

  column_write_dispatch #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_COL    (NC),
    .ROW_LEN    (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .col_ptr    (col_ptr),
    .frame_done (frame_done),
    .ovf_err    (ovf_err)
  );

  typedef struct {
    int          due;
    int          col;
    logic [7:0]  data;
  } wr_t;

  wr_t    sb[$];
  wr_t    mon_e;
  int     cyc = 0;
  int     n_assert = 0;
  int     n_fail = 0;

  // Reference model state
  int     occ_m[NC];
  int     col_m;
  int     cnt_m;
  state_e st_m;
  bit     ovf_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] word(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Write monitor: every cycle either the expected write or no write at all.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("wr_req", 64'(bus.wr_req_p), 64'(1) << mon_e.col);
        check("wr_data", 64'(bus.wr_data_p[mon_e.col*DW +: DW]), 64'(mon_e.data));
      end else begin
        check("wr_idle", 64'(bus.wr_req_p), 64'(0));
      end
    end
  end

  task automatic model_reset();
    for (int c = 0; c < NC; c++) occ_m[c] = 0;
    col_m = 0;
    cnt_m = 0;
    st_m  = StIdle;
    ovf_m = 1'b0;
  endtask

  task automatic apply_reset(input bit hold_valid);
    reset        = 1'b1;
    bus.in_valid = hold_valid;
    bus.in_data  = 8'hA5;
    bus.in_last  = 1'b0;
    bus.rd_ack   = '0;
    sb.delete();
    model_reset();
    @(posedge clk); #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_wr_req", 64'(bus.wr_req_p), 64'(0));
    check("rst_wr_data", 64'(bus.wr_data_p), 64'(0));
    check("rst_col_ptr", 64'(col_ptr), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_ovf_err", 64'(ovf_err), 64'(0));
    reset        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // One cycle of stimulus; checks combinational/registered status against the model.
  task automatic drive(input bit v, input logic [7:0] d, input bit last,
                       input logic [NC-1:0] ack, output bit acc);
    bit exp_rdy;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.rd_ack   = ack;
    #1;
    exp_rdy = (st_m != StDone) && (occ_m[col_m] < DEP);
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("col_ptr", 64'(col_ptr), 64'(col_m));
    check("frame_done", 64'(frame_done), 64'(st_m == StDone));
    check("ovf_err", 64'(ovf_err), 64'(ovf_m));
    acc = v && exp_rdy;
    if (acc) sb.push_back('{cyc + 1, col_m, d});
    for (int c = 0; c < NC; c++) begin
      if (acc && col_m == c && !ack[c]) begin
        if (occ_m[c] < DEP) occ_m[c]++;
      end else if (ack[c] && !(acc && col_m == c)) begin
        if (occ_m[c] == 0) ovf_m = 1'b1;
        else occ_m[c]--;
      end
    end
    if (st_m == StDone) begin
      st_m = StIdle;
    end else if (acc) begin
      if (last) begin
        st_m  = StDone;
        col_m = 0;
        cnt_m = 0;
      end else begin
        st_m = StFill;
        if (cnt_m == RL - 1) begin
          cnt_m = 0;
          col_m = (col_m + 1) % NC;
        end else begin
          cnt_m++;
        end
      end
    end
    @(posedge clk); #2;
  endtask

  task automatic send_words(input int n, input int base, input bit last_at_end);
    int sent = 0;
    int tries = 0;
    bit acc;
    while (sent < n && tries < 4 * n + 16) begin
      drive(1'b1, word(base + sent), last_at_end && (sent == n - 1), '0, acc);
      if (acc) sent++;
      tries++;
    end
    check("send_count", 64'(sent), 64'(n));
  endtask

  initial begin
    bit acc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.rd_ack   = '0;
    model_reset();
    @(posedge clk); #2;
    apply_reset(1'b0);

    // 1: one 64-word frame, one row per column
    send_words(64, 0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, '0, acc);
    drive(1'b0, 8'h00, 1'b0, '0, acc);
    for (int c = 0; c < NC; c++) check("t1_occ", 64'(dut.occ[c]), 64'(16));

    // 2: three more frames fill every column to DEPTH, then upstream stalls
    send_words(64, 64, 1'b1);
    send_words(64, 128, 1'b1);
    send_words(64, 192, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, word(256), 1'b0, '0, acc);
      check("t2_no_accept", 64'(acc), 64'(0));
    end
    for (int c = 0; c < NC; c++) check("t2_occ_full", 64'(dut.occ[c]), 64'(DEP));

    // 3: one pop on column 0 frees exactly one slot
    drive(1'b1, word(256), 1'b0, 4'b0001, acc);
    check("t3_occ0_after_pop", 64'(dut.occ[0]), 64'(DEP - 1));
    drive(1'b1, word(256), 1'b0, '0, acc);
    check("t3_accept", 64'(acc), 64'(1));
    drive(1'b1, word(257), 1'b0, '0, acc);
    drive(1'b0, 8'h00, 1'b0, '0, acc);
    check("t3_occ0_refull", 64'(dut.occ[0]), 64'(DEP));
    check("t3_sb_drained", 64'(sb.size()), 64'(0));

    // 4: write and pop on column 1 in the same cycle
    apply_reset(1'b0);
    send_words(26, 300, 1'b0);
    check("t4_occ1_pre", 64'(dut.occ[1]), 64'(10));
    drive(1'b1, word(326), 1'b0, 4'b0010, acc);
    check("t4_accept", 64'(acc), 64'(1));
    check("t4_occ1_hold", 64'(dut.occ[1]), 64'(10));

    // 5: pop from an empty column sets the sticky error
    drive(1'b0, 8'h00, 1'b0, 4'b0100, acc);
    check("t5_ovf_set", 64'(ovf_err), 64'(1));
    check("t5_occ2_zero", 64'(dut.occ[2]), 64'(0));
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, '0, acc);
    check("t5_ovf_sticky", 64'(ovf_err), 64'(1));

    // 6: reset mid-row on column 2
    send_words(5, 327, 1'b0);
    send_words(7, 332, 1'b0);
    check("t6_col_ptr_pre", 64'(col_ptr), 64'(2));
    apply_reset(1'b1);
    drive(1'b0, 8'h00, 1'b0, '0, acc);
    drive(1'b0, 8'h00, 1'b0, '0, acc);
    check("end_sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
